ttl_pulse_driver: RTL and testbench
===================================

TTL_PULSE_DRIVER -- requirements
Module: ttl_pulse_driver

Interface
REQ-001 SHALL have parameter OUTPUT_NUM, default 8: number of TTL channels (1..16).
REQ-002 SHALL have parameter WIDTH_BITS, default 16: pulse-width counter width.
REQ-003 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port cmd_valid, input, 1: command strobe from the GPO stage (its selected pulse).
REQ-006 SHALL have port cmd_data, input, 128: command word from the GPO stage (gpo_out).
REQ-007 SHALL have port clr_collision, input, 1: clears the collision_ch sticky bits.
REQ-008 SHALL have port ttl_out, output, OUTPUT_NUM: registered TTL pin levels.
REQ-009 SHALL have port busy, output, 1: high while any channel has a pulse in progress.
REQ-010 SHALL have port collision, output, 1: one-cycle flag for a command hitting a busy channel.
REQ-011 SHALL have port collision_ch, output, OUTPUT_NUM: sticky per-channel collision bits.

Function
REQ-012 SHALL decode cmd_data fields as follows: [15:0] level, [31:16] mask, [33:32] mode, [32+WIDTH_BITS+1:34] width; bits above 15 of level/mask beyond OUTPUT_NUM are ignored.
REQ-013 SHALL accept a command on every clk edge where cmd_valid=1, with no backpressure; only channels whose mask bit is 1 are affected.
REQ-014 SHALL support mode 0 (SET): ttl_out[i] <= level[i], registered one cycle after acceptance.
REQ-015 SHALL support mode 1 (PULSE): ttl_out[i] goes high the cycle after acceptance and stays high for exactly max(width,1) cycles, then goes low.
REQ-016 SHALL support mode 2 (TOGGLE): ttl_out[i] <= ~ttl_out[i].
REQ-017 SHALL treat mode 3 as reserved: no output change, collision=1 for one cycle, and no collision_ch bits set.
REQ-018 SHALL keep per-channel state IDLE/PULSING: PULSE moves to PULSING with cnt=max(width,1)-1; in PULSING cnt decrements each cycle; cnt==0 returns to IDLE with output low.
REQ-019 SHALL treat any masked command to a PULSING channel as a collision: the new command takes effect (SET/TOGGLE go to IDLE; PULSE restarts its count), collision=1 next cycle, and collision_ch[i] is set.
REQ-020 SHALL apply the new command when it arrives in the same cycle as a pulse's final cycle (cnt==0), and flag it as a collision.
REQ-021 SHALL drive busy = OR of all PULSING states, registered.
REQ-022 SHALL give set priority over clear when clr_collision coincides with a new collision on the same bit.

Reset
REQ-023 SHALL, while reset=0, force ttl_out=0, busy=0, collision=0, collision_ch=0, all channels IDLE and all cnt=0.
REQ-024 SHALL let reset asserted mid-pulse terminate the pulse immediately, and SHALL ignore cmd_valid during reset.

Configuration
REQ-025 SHALL gate the edge counters with macro TTL_EDGE_COUNT_EN.
REQ-026 SHALL, with TTL_EDGE_COUNT_EN defined, add output edge_count, width OUTPUT_NUM*32: a per-channel 32-bit wrap-around count of ttl_out rising edges, cleared by reset.
REQ-027 SHALL, without TTL_EDGE_COUNT_EN, omit the edge_count port and its logic, with all other behaviour identical.

Structure
REQ-028 SHALL place the mode encoding enum (SET, PULSE, TOGGLE, RSVD), the field offsets and the channel-state enum in a shared package ttl_pkg.
REQ-029 SHALL implement per-channel state, counter and output in sub-module ttl_pulse_channel, instantiated OUTPUT_NUM times by generate.
REQ-030 SHALL keep command decode and the collision/busy aggregation in the top module.

Verification
REQ-031 SHALL cover: SET, mask=0x05, level=0xFF -> ttl_out=0x05 one cycle after the strobe.
REQ-032 SHALL cover: PULSE on ch3, width=4 -> ttl_out[3] high for exactly 4 cycles, busy high for the same 4 cycles.
REQ-033 SHALL cover: PULSE width=0 on ch0 -> a 1-cycle pulse, with no collision.
REQ-034 SHALL cover: PULSE ch1 width=10, then TOGGLE ch1 at cycle 5 -> collision pulse, collision_ch=0x02, ttl_out[1]=0 and the channel IDLE.
REQ-035 SHALL cover: PULSE ch2 width=3 with a re-PULSE on its last cycle -> continuous high for 3 more cycles, collision flagged; then clr_collision clears collision_ch.
REQ-036 SHALL cover: reset=0 asserted mid-pulse -> all outputs 0 on the next edge; with TTL_EDGE_COUNT_EN, edge_count=0.

Source files
------------

// File: rtl/ttl_pkg.sv
// Shared definitions for the TTL pulse driver: command modes,
// command field offsets and per-channel state encoding.
package ttl_pkg;

    typedef enum logic [1:0] {
        MODE_SET    = 2'd0,
        MODE_PULSE  = 2'd1,
        MODE_TOGGLE = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    typedef enum logic {
        CH_IDLE    = 1'b0,
        CH_PULSING = 1'b1
    } ch_state_e;

    localparam int CMD_BITS  = 128;
    localparam int LEVEL_LSB = 0;
    localparam int MASK_LSB  = 16;
    localparam int MODE_LSB  = 32;
    localparam int WIDTH_LSB = 34;
    localparam int MAX_CH    = 16;

endpackage

// File: rtl/ttl_pulse_channel.sv
// One TTL channel: IDLE/PULSING state, down-counter and output pin.
// Optional rising-edge counter enabled by macro TTL_EDGE_COUNT_EN.
import ttl_pkg::*;

module ttl_pulse_channel #(
    parameter int WIDTH_BITS = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  hit,
    input  logic [1:0]            mode,
    input  logic                  level,
    input  logic [WIDTH_BITS-1:0] width,
    output logic                  out,
    output logic                  pulsing
`ifdef TTL_EDGE_COUNT_EN
    ,
    output logic [31:0]           edge_count
`endif
);

    localparam logic [WIDTH_BITS-1:0] ONE = WIDTH_BITS'(1);

    ch_state_e             state;
    ch_state_e             state_next;
    logic [WIDTH_BITS-1:0] cnt;
    logic [WIDTH_BITS-1:0] cnt_next;
    logic                  out_next;
    mode_e                 cmd_mode;

    assign cmd_mode = mode_e'(mode);
    assign pulsing  = (state == CH_PULSING);

    // State, counter and pin registers; reset ends any pulse at once.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= CH_IDLE;
            cnt   <= '0;
            out   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            out   <= out_next;
        end
    end

    // A new command always wins over the running pulse, even on its last cycle.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        out_next   = out;
        if (hit) begin
            unique case (cmd_mode)
                MODE_SET: begin
                    out_next   = level;
                    state_next = CH_IDLE;
                    cnt_next   = '0;
                end
                MODE_PULSE: begin
                    out_next   = 1'b1;
                    state_next = CH_PULSING;
                    cnt_next   = (width == '0) ? '0 : width - ONE;
                end
                MODE_TOGGLE: begin
                    out_next   = ~out;
                    state_next = CH_IDLE;
                    cnt_next   = '0;
                end
                MODE_RSVD: begin
                    out_next   = out;
                end
            endcase
        end else if (state == CH_PULSING) begin
            if (cnt == '0) begin
                out_next   = 1'b0;
                state_next = CH_IDLE;
            end else begin
                cnt_next = cnt - ONE;
            end
        end
    end

`ifdef TTL_EDGE_COUNT_EN
    // Count rising edges in step with the pin update, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (!reset) begin
            edge_count <= '0;
        end else if (out_next && !out) begin
            edge_count <= edge_count + 32'd1;
        end
    end
`endif

endmodule

// File: rtl/ttl_pulse_driver.sv
// Multi-channel TTL driver: decodes GPO command words into per-channel
// SET/PULSE/TOGGLE actions and reports collisions. Macro: TTL_EDGE_COUNT_EN.
import ttl_pkg::*;

module ttl_pulse_driver #(
    parameter int OUTPUT_NUM = 8,
    parameter int WIDTH_BITS = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    input  logic [127:0]          cmd_data,
    input  logic                  clr_collision,
    output logic [OUTPUT_NUM-1:0] ttl_out,
    output logic                  busy,
    output logic                  collision,
    output logic [OUTPUT_NUM-1:0] collision_ch
`ifdef TTL_EDGE_COUNT_EN
    ,
    output logic [OUTPUT_NUM*32-1:0] edge_count
`endif
);

    logic [OUTPUT_NUM-1:0] level;
    logic [OUTPUT_NUM-1:0] mask;
    logic [1:0]            mode;
    logic [WIDTH_BITS-1:0] width;
    logic                  act;
    logic                  rsvd;
    logic [OUTPUT_NUM-1:0] hit;
    logic [OUTPUT_NUM-1:0] pulsing;
    logic                  unused;

    assign level  = cmd_data[LEVEL_LSB +: OUTPUT_NUM];
    assign mask   = cmd_data[MASK_LSB +: OUTPUT_NUM];
    assign mode   = cmd_data[MODE_LSB +: 2];
    assign width  = cmd_data[WIDTH_LSB +: WIDTH_BITS];
    assign unused = ^cmd_data;

    assign rsvd = (mode_e'(mode) == MODE_RSVD);
    assign act  = cmd_valid && !rsvd;
    assign hit  = {OUTPUT_NUM{act}} & mask;
    assign busy = |pulsing;

    for (genvar i = 0; i < OUTPUT_NUM; i++) begin : g_ch
        ttl_pulse_channel #(
            .WIDTH_BITS(WIDTH_BITS)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .hit       (hit[i]),
            .mode      (mode),
            .level     (level[i]),
            .width     (width),
            .out       (ttl_out[i]),
            .pulsing   (pulsing[i])
`ifdef TTL_EDGE_COUNT_EN
            ,
            .edge_count(edge_count[i*32 +: 32])
`endif
        );
    end

    // Collision flag and sticky bits; a new collision beats a clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            collision    <= 1'b0;
            collision_ch <= '0;
        end else begin
            collision    <= cmd_valid && (rsvd || |(mask & pulsing));
            collision_ch <= (collision_ch & ~{OUTPUT_NUM{clr_collision}})
                          | (hit & pulsing);
        end
    end

endmodule

// File: tb/tb_ttl_pulse_driver.sv
// Scoreboard bench for ttl_pulse_driver: directed commands push expected
// post-edge pin/flag state; a monitor pops and compares mid-cycle.
module tb_ttl_pulse_driver;

    typedef struct {
        int          cyc;
        logic [7:0]  ttl;
        logic        busy;
        logic        col;
        logic [7:0]  colch;
        string       name;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         cmd_valid;
    logic [127:0] cmd_data;
    logic         clr_collision;
    logic [7:0]   ttl_out;
    logic         busy;
    logic         collision;
    logic [7:0]   collision_ch;
`ifdef TTL_EDGE_COUNT_EN
    logic [255:0] edge_count;
`endif

    exp_t q[$];
    int   cyc;
    int   checks;
    int   errors;
    bit   done;

    ttl_pulse_driver #(
        .OUTPUT_NUM(8),
        .WIDTH_BITS(16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_data     (cmd_data),
        .clr_collision(clr_collision),
        .ttl_out      (ttl_out),
        .busy         (busy),
        .collision    (collision),
        .collision_ch (collision_ch)
`ifdef TTL_EDGE_COUNT_EN
        ,
        .edge_count   (edge_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] mk(input int mode, input logic [7:0] mask,
                                        input logic [7:0] level, input int width);
        logic [127:0] c;
        c = '0;
        c[7:0]   = level;
        c[23:16] = mask;
        c[33:32] = mode[1:0];
        c[49:34] = width[15:0];
        return c;
    endfunction

    // One clock of stimulus; expectation is the state after the next edge.
    task automatic step(input logic v, input logic [127:0] d, input logic clr,
                        input logic rst, input logic [7:0] e_ttl,
                        input logic e_busy, input logic e_col,
                        input logic [7:0] e_colch, input string name);
        exp_t e;
        cmd_valid     = v;
        cmd_data      = d;
        clr_collision = clr;
        reset         = rst;
        e.cyc   = cyc + 1;
        e.ttl   = e_ttl;
        e.busy  = e_busy;
        e.col   = e_col;
        e.colch = e_colch;
        e.name  = name;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every due expectation half a cycle after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                checks++;
                if (e.cyc != cyc ||
                    ttl_out !== e.ttl || busy !== e.busy ||
                    collision !== e.col || collision_ch !== e.colch) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got ttl=%h busy=%b col=%b colch=%h exp ttl=%h busy=%b col=%b colch=%h",
                             e.name, cyc, ttl_out, busy, collision, collision_ch,
                             e.ttl, e.busy, e.col, e.colch);
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        done   = 1'b0;
        reset = 1'b0;
        cmd_valid = 1'b0;
        cmd_data = '0;
        clr_collision = 1'b0;
        @(posedge clk);
        #1;
        //   v  data                    clr rst ttl   bsy col colch
        step(1, mk(0, 8'hFF, 8'hFF, 0), 0, 0, 8'h00, 0, 0, 8'h00, "rst_ignore_cmd");
        step(0, '0,                     0, 0, 8'h00, 0, 0, 8'h00, "rst_hold");
        step(0, '0,                     0, 1, 8'h00, 0, 0, 8'h00, "rst_release");
        step(1, mk(0, 8'h05, 8'hFF, 0), 0, 1, 8'h05, 0, 0, 8'h00, "set_mask05");
        step(0, '0,                     0, 1, 8'h05, 0, 0, 8'h00, "set_hold");
        step(1, mk(0, 8'hFF, 8'h00, 0), 0, 1, 8'h00, 0, 0, 8'h00, "set_clear");
        step(1, mk(1, 8'h08, 8'h00, 4), 0, 1, 8'h08, 1, 0, 8'h00, "p3_c1");
        step(0, '0,                     0, 1, 8'h08, 1, 0, 8'h00, "p3_c2");
        step(0, '0,                     0, 1, 8'h08, 1, 0, 8'h00, "p3_c3");
        step(0, '0,                     0, 1, 8'h08, 1, 0, 8'h00, "p3_c4");
        step(0, '0,                     0, 1, 8'h00, 0, 0, 8'h00, "p3_end");
        step(0, '0,                     0, 1, 8'h00, 0, 0, 8'h00, "p3_idle");
        step(1, mk(1, 8'h01, 8'h00, 0), 0, 1, 8'h01, 1, 0, 8'h00, "w0_c1");
        step(0, '0,                     0, 1, 8'h00, 0, 0, 8'h00, "w0_end");
        step(1, mk(1, 8'h02, 8'h00, 10),0, 1, 8'h02, 1, 0, 8'h00, "p1_c1");
        step(0, '0,                     0, 1, 8'h02, 1, 0, 8'h00, "p1_c2");
        step(0, '0,                     0, 1, 8'h02, 1, 0, 8'h00, "p1_c3");
        step(0, '0,                     0, 1, 8'h02, 1, 0, 8'h00, "p1_c4");
        step(1, mk(2, 8'h02, 8'h00, 0), 0, 1, 8'h00, 0, 1, 8'h02, "tog_collide");
        step(0, '0,                     0, 1, 8'h00, 0, 0, 8'h02, "tog_sticky");
        step(0, '0,                     1, 1, 8'h00, 0, 0, 8'h00, "clr_1");
        step(1, mk(1, 8'h04, 8'h00, 3), 0, 1, 8'h04, 1, 0, 8'h00, "p2_c1");
        step(0, '0,                     0, 1, 8'h04, 1, 0, 8'h00, "p2_c2");
        step(0, '0,                     0, 1, 8'h04, 1, 0, 8'h00, "p2_c3");
        step(1, mk(1, 8'h04, 8'h00, 3), 0, 1, 8'h04, 1, 1, 8'h04, "p2_repulse");
        step(0, '0,                     0, 1, 8'h04, 1, 0, 8'h04, "p2_r2");
        step(0, '0,                     0, 1, 8'h04, 1, 0, 8'h04, "p2_r3");
        step(0, '0,                     1, 1, 8'h00, 0, 0, 8'h00, "p2_end_clr");
        step(1, mk(1, 8'h20, 8'h00, 5), 0, 1, 8'h20, 1, 0, 8'h00, "p5_c1");
        step(1, mk(1, 8'h20, 8'h00, 5), 1, 1, 8'h20, 1, 1, 8'h20, "set_over_clr");
        step(0, '0,                     0, 1, 8'h20, 1, 0, 8'h20, "p5_hold");
        step(1, mk(3, 8'hFF, 8'hFF, 0), 0, 1, 8'h20, 1, 1, 8'h20, "rsvd_mode");
        step(0, '0,                     0, 1, 8'h20, 1, 0, 8'h20, "rsvd_after");
        step(1, mk(0, 8'h01, 8'h01, 0), 0, 1, 8'h21, 1, 0, 8'h20, "set_idle_ch");
        step(0, '0,                     0, 1, 8'h01, 0, 0, 8'h20, "p5_end");
        step(1, mk(2, 8'h03, 8'h00, 0), 0, 1, 8'h02, 0, 0, 8'h20, "toggle_idle");
        step(1, mk(1, 8'h80, 8'h00, 8), 0, 1, 8'h82, 1, 0, 8'h20, "p7_c1");
        step(0, '0,                     0, 1, 8'h82, 1, 0, 8'h20, "p7_c2");
        step(0, '0,                     0, 0, 8'h00, 0, 0, 8'h00, "mid_reset");
`ifdef TTL_EDGE_COUNT_EN
        @(negedge clk);
        checks++;
        if (edge_count !== '0) begin
            errors++;
            $display("FAIL edge_count_reset got=%h exp=0", edge_count);
        end
        @(posedge clk);
        #1;
`endif
        step(0, '0,                     0, 1, 8'h00, 0, 0, 8'h00, "post_reset");
        repeat (4) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending exp=0", q.size());
        end
        done = 1'b1;
    end

    initial begin
        fork
            wait (done);
            begin
                #20000;
                errors++;
                $display("FAIL timeout got=running exp=done");
            end
        join_any
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
